// File: rtl/serial_adder_seq.sv
// Bit-serial ripple adder: operands are shifted out LSB first, one sum bit per
// clock, and the completed sum/carry are published with a one-cycle done pulse.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must reach WIDTH itself, hence WIDTH+1 distinct values.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    logic             bit_s;
    logic             carry_nx;
    logic [WIDTH-1:0] res_nx;

    assign bit_s    = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign carry_nx = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    assign res_nx   = {bit_s, res_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    res_d   = res_nx;
                    carry_d = carry_nx;
                    a_sh_d  = a_sh_q >> 1;
                    b_sh_d  = b_sh_q >> 1;
                    cnt_d   = cnt_q + CW'(1);
                    // Last bit: publish the result including the bit formed this edge.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        sum_d   = res_nx;
                        cout_d  = carry_nx;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign ready = (state_q == IDLE);
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);
    assign sum   = sum_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq at WIDTH=8 with hand-computed sums.
module tb_serial_adder_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_vec;
    int n_err;

    serial_adder_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One addition; inj>0 drives a stray start (0x22+0x11) during RUN cycle inj.
    task automatic do_add(input logic [7:0] ta, input logic [7:0] tb_v, input int inj,
                          input logic [7:0] es, input logic ec);
        int lat;
        int busy_n;
        @(negedge clk);
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 99;
        busy_n = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (busy) busy_n++;
            if (c == inj) begin
                start = 1'b1; a = 8'h22; b = 8'h11;
            end else begin
                start = 1'b0;
            end
        end
        chk("latency", lat, 9);
        chk("busy_cycles", busy_n, 8);
        chk("sum", {24'd0, sum}, {24'd0, es});
        chk("cout", {31'd0, cout}, {31'd0, ec});
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("ready_after", {31'd0, ready}, 32'd1);
        $display("add 0x%02h + 0x%02h -> sum=0x%02h cout=%0d (latency %0d)", ta, tb_v, sum, cout, lat);
    endtask

    logic [7:0] bb_a   [4] = '{8'h12, 8'hF0, 8'h7F, 8'hAA};
    logic [7:0] bb_b   [4] = '{8'h34, 8'h20, 8'h7F, 8'h55};
    logic [7:0] bb_s   [4] = '{8'h46, 8'h10, 8'hFE, 8'hFF};
    logic       bb_c   [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int acc_idx;
        int done_idx;
        int last_acc;
        int last_done;
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0;

        // Reset state, observed while rst is still asserted.
        #2;
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_sum", {24'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        #10 rst = 1'b0;

        do_add(8'h0F, 8'h01, 0, 8'h10, 1'b0);

        // Abort on the 8th RUN edge: completion is suppressed.
        @(negedge clk);
        a = 8'h33; b = 8'h44; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("abort_no_done", {31'd0, done}, 32'd0);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_sum", {24'd0, sum}, 32'h10);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        $display("abort 0x33 + 0x44 at bit 8 -> sum=0x%02h ready=%0d", sum, ready);

        do_add(8'hFF, 8'h01, 0, 8'h00, 1'b1);
        do_add(8'hFF, 8'hFF, 0, 8'hFE, 1'b1);
        do_add(8'h00, 8'h00, 0, 8'h00, 1'b0);
        do_add(8'h05, 8'h03, 3, 8'h08, 1'b0);

        // Reset pulse between edges in the middle of RUN.
        @(negedge clk);
        a = 8'h0F; b = 8'h0F; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, ready}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_sum", {24'd0, sum}, 32'd0);
        chk("midrst_cout", {31'd0, cout}, 32'd0);
        #1 rst = 1'b0;
        $display("reset mid-run -> ready=%0d busy=%0d sum=0x%02h", ready, busy, sum);
        do_add(8'h80, 8'h80, 0, 8'h00, 1'b1);

        // Back-to-back with start held high; new operands presented whenever idle.
        acc_idx = 0; done_idx = 0; last_acc = -1; last_done = -1;
        @(negedge clk);
        for (int c = 0; c < 100 && done_idx < 4; c++) begin
            if (done) begin
                chk("b2b_sum", {24'd0, sum}, {24'd0, bb_s[done_idx]});
                chk("b2b_cout", {31'd0, cout}, {31'd0, bb_c[done_idx]});
                if (last_done >= 0) chk("b2b_done_gap", c - last_done, 10);
                $display("b2b 0x%02h + 0x%02h -> sum=0x%02h cout=%0d at cycle %0d",
                         bb_a[done_idx], bb_b[done_idx], sum, cout, c);
                last_done = c;
                done_idx++;
            end
            if (ready) begin
                if (last_acc >= 0) chk("b2b_accept_gap", c - last_acc, 10);
                last_acc = c;
                if (acc_idx < 4) begin
                    a = bb_a[acc_idx]; b = bb_b[acc_idx]; start = 1'b1;
                    acc_idx++;
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_results", done_idx, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_adder_seq.md
SERIAL_ADDER_SEQ -- requirements
Module: serial_adder_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to add a and b; accepted only when ready=1.
REQ-005 SHALL have port abort  input  1  synchronous cancel of an addition in progress.
REQ-006 SHALL have port a  input  WIDTH  first operand, sampled on the accepting edge only.
REQ-007 SHALL have port b  input  WIDTH  second operand, sampled on the accepting edge only.
REQ-008 SHALL have port ready  output  1  high in IDLE; start is accepted.
REQ-009 SHALL have port busy  output  1  high in RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a result is published.
REQ-011 SHALL have port sum  output  WIDTH  last published sum, registered.
REQ-012 SHALL have port cout  output  1  last published carry-out, registered.

Function
REQ-013 SHALL implement a 3-state FSM: IDLE, RUN, DONE; ready=(IDLE), busy=(RUN), done=(DONE), all decoded from registered state.
REQ-014 SHALL accept start on a rising edge when state=IDLE and start=1: load a, b into operand shift registers, clear the carry flop, clear the bit counter, clear the internal result shift register, enter RUN.
REQ-015 SHALL, on each RUN edge, compute bit s = a_sh[0] ^ b_sh[0] ^ c, next carry = majority(a_sh[0], b_sh[0], c), shift s into the result register from the MSB end, shift both operand registers right by one, increment the counter.
REQ-016 SHALL process operands LSB first, exactly WIDTH bits; after the WIDTH-th RUN edge the state SHALL be DONE.
REQ-017 SHALL, on the edge entering DONE, copy the result register to sum and the final carry to cout; sum and cout SHALL otherwise hold.
REQ-018 SHALL remain in DONE exactly one cycle, then return to IDLE unconditionally.
REQ-019 SHALL give latency: start accepted at edge k -> done=1 during the cycle following edge k+WIDTH, with sum/cout valid from that cycle onward.
REQ-020 SHALL ignore start while in RUN or DONE (no reload, no queueing).
REQ-021 SHALL, if abort=1 on an edge in RUN (including the WIDTH-th bit edge), go to IDLE with no done pulse and sum/cout unchanged; abort wins over completion.
REQ-022 SHALL treat abort as no effect in IDLE and DONE; start=1 and abort=1 together in IDLE SHALL accept start.
REQ-023 SHALL produce sum+cout equal to the (WIDTH+1)-bit unsigned sum a+b; wrap-around of sum is modulo 2^WIDTH with the overflow in cout.
REQ-024 SHALL size the bit counter to hold 0..WIDTH without overflow for every legal WIDTH.
REQ-025 SHALL allow a new start on the first IDLE cycle after DONE (back-to-back throughput of one result per WIDTH+2 cycles).

Reset
REQ-026 SHALL, while rst=1, force state=IDLE, sum=0, cout=0, carry=0, counter=0, operand and result registers=0, asynchronously and independent of clk.
REQ-027 SHALL give outputs during/after reset: ready=1, busy=0, done=0.
REQ-028 SHALL, on rst asserted mid-RUN, discard the addition with no done pulse; the first edge after rst deasserts behaves as IDLE.

Verification
REQ-029 SHALL verify (WIDTH=8) a=0x0F, b=0x01, start at edge k -> done=1 after edge k+8 only, sum=0x10, cout=0, busy high exactly 8 cycles.
REQ-030 SHALL verify a=0xFF, b=0x01 -> sum=0x00, cout=1; a=0xFF, b=0xFF -> sum=0xFE, cout=1; a=0x00, b=0x00 -> sum=0x00, cout=0.
REQ-031 SHALL verify start=1 with a=0x22, b=0x11 at RUN cycle 3 of an 0x05+0x03 addition -> ignored, result sum=0x08, cout=0.
REQ-032 SHALL verify abort at the 8th RUN edge after a prior result 0x10 -> no done, sum stays 0x10, ready=1 next cycle.
REQ-033 SHALL verify rst pulsed mid-RUN (between edges) -> immediately ready=1, busy=0, sum=0, cout=0; following start 0x80+0x80 gives sum=0x00, cout=1.
REQ-034 SHALL verify back-to-back: start held high continuously -> starts accepted every 10 cycles, done pulses spaced 10 cycles, each sum matching a+b sampled at its accepting edge.
